// File: rtl/uart_pkg.sv
// Shared UART types and constants for the rx and tx control paths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} rx_state_t;

  localparam int DATA_BITS = 8;

  // 50 MHz core clock at 9600 baud; the tx baud generator uses the same value.
  localparam int CLKS_PER_BIT_DEFAULT = 5208;

endpackage

// File: rtl/rx_sync_edge.sv
// Brings the asynchronous rx line into the clk domain and flags its falling edge.
// Latency: rx_sync lags the pin by 2 clk; rx_fall is combinational from the flops.
// Backpressure: none; the line is sampled every cycle.
module rx_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic rx_pin_in,
  output logic rx_sync,
  output logic rx_fall
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  // Flops reset to the idle-high line level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      dly_q  <= 1'b1;
    end else begin
      meta_q <= rx_pin_in;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign rx_sync = sync_q;
  assign rx_fall = dly_q & ~sync_q;

endmodule

// File: rtl/rx_control_module.sv
// UART 8N1 receiver: mid-bit sampling, one-cycle done pulse, framing-error pulse.
// Latency: rx_done_sig rises 1 clk after the stop-bit sample (~9.5 bit times + 3 clk from the start edge).
// Backpressure: none; rx_done_sig is a single-cycle pulse, rx_data is held until the next good frame.
module rx_control_module
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin_in,
  input  logic                 rx_en_sig,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done_sig,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic rx_sync;
  logic rx_fall;

  rx_sync_edge u_sync_edge (
    .clk       (clk),
    .rst       (rst),
    .rx_pin_in (rx_pin_in),
    .rx_sync   (rx_sync),
    .rx_fall   (rx_fall)
  );

  rx_state_t            state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 done_d;
  logic                 err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      rx_data      <= '0;
      rx_done_sig  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      rx_data      <= data_d;
      rx_done_sig  <= done_d;
      rx_frame_err <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = rx_data;
    done_d  = 1'b0;
    err_d   = 1'b0;

    // Dropping enable aborts silently and wins over any sample due this cycle.
    if (state_q != IDLE && !rx_en_sig) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_en_sig && rx_fall) begin
            state_d = START;
            baud_d  = '0;
            bit_d   = '0;
          end
        end
        START: begin
          if (baud_q == HALF_LAST) begin
            baud_d  = '0;
            state_d = rx_sync ? IDLE : DATA;
          end else begin
            baud_d = baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_q == BIT_LAST) begin
            baud_d  = '0;
            shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == LAST_BIT) state_d = STOP;
          end else begin
            baud_d = baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_q == BIT_LAST) begin
            baud_d = '0;
            if (rx_sync) begin
              data_d  = shift_q;
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end else begin
            baud_d = baud_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_rx_control_module.sv
// Randomised and directed 8N1 frames; a scoreboard checks every done/error pulse against a byte-level model.
module tb_rx_control_module;

  localparam int CPB     = 16;
  // Posedges from driving the start edge to the done/error pulse: 2 sync + 1 edge + (CPB/2-1) + 9*CPB.
  localparam int LAT_NOM = CPB / 2 + 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_pin_in;
  logic       rx_en_sig;
  logic [7:0] rx_data;
  logic       rx_done_sig;
  logic       rx_frame_err;
  logic       rx_busy;

  always #5 clk = ~clk;

  rx_control_module #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_pin_in    (rx_pin_in),
    .rx_en_sig    (rx_en_sig),
    .rx_data      (rx_data),
    .rx_done_sig  (rx_done_sig),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         start_cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         mon_lat;
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (rx_done_sig || rx_frame_err)) begin
      check("done_err_exclusive", rx_done_sig & rx_frame_err, 0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: done=%0b err=%0b data=0x%0h, nothing expected (cycle %0d)",
                 rx_done_sig, rx_frame_err, rx_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_is_err", rx_frame_err, mon_e.is_err);
        check("pulse_rx_data", rx_data, mon_e.data);
        check("pulse_busy", rx_busy, mon_e.is_err ? 0 : 1);
        mon_lat = cyc - mon_e.start_cyc;
        checks++;
        if (mon_lat < LAT_NOM - 2 || mon_lat > LAT_NOM + 2) begin
          failures++;
          $display("FAIL pulse_latency: got %0d clk, expected %0d +/- 2", mon_lat, LAT_NOM);
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_pin_in = 1'b1;
    end
  endtask

  // act: 0 = normal frame, 1 = drop enable mid data bit act_bit, 2 = reset mid data bit act_bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_val, input int act, input int act_bit);
    logic [9:0] bits;
    exp_t       e;
    bits = {stop_val, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (k == 0 && c == 0 && act == 0) begin
          e.is_err    = !stop_val;
          e.data      = stop_val ? b : last_good;
          e.start_cyc = cyc;
          exp_q.push_back(e);
          if (stop_val) last_good = b;
        end
        if (act != 0 && k == act_bit + 1 && c == CPB / 2) begin
          check("busy_before_abort", rx_busy, 1);
          if (act == 1) rx_en_sig = 1'b0;
          else begin
            rst       = 1'b1;
            last_good = 8'h00;
          end
        end
        if (act != 0 && k == act_bit + 1 && c == CPB / 2 + 1) begin
          check("abort_busy", rx_busy, 0);
          check("abort_done", rx_done_sig, 0);
          check("abort_err", rx_frame_err, 0);
          check("abort_rx_data", rx_data, last_good);
        end
        rx_pin_in = bits[k];
      end
    end
    if (act != 0) begin
      @(negedge clk);
      rst       = 1'b0;
      rx_en_sig = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    rx_en_sig = 1'b1;
    rx_pin_in = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_rx_data", rx_data, 0);
    check("reset_done", rx_done_sig, 0);
    check("reset_err", rx_frame_err, 0);
    check("reset_busy", rx_busy, 0);
    rst = 1'b0;
    idle(2 * CPB);

    send_frame(8'hA5, 1'b1, 0, 0);
    idle(2 * CPB);
    check("a5_idle_busy", rx_busy, 0);
    check("a5_held_data", rx_data, 8'hA5);

    // Short glitch: must start a frame then abandon it at the half-bit sample.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 4) check("glitch_busy_start", rx_busy, 1);
      rx_pin_in = 1'b0;
    end
    idle(2 * CPB);
    check("glitch_busy_end", rx_busy, 0);
    check("glitch_rx_data", rx_data, 8'hA5);

    // Framing error followed by a held-low break line.
    send_frame(8'h3C, 1'b0, 0, 0);
    for (int c = 0; c < 3 * CPB; c++) begin
      @(negedge clk);
      rx_pin_in = 1'b0;
    end
    check("break_no_retrigger", rx_busy, 0);
    check("break_rx_data", rx_data, 8'hA5);
    idle(2 * CPB);

    send_frame(8'h00, 1'b1, 0, 0);
    send_frame(8'hFF, 1'b1, 0, 0);
    idle(2 * CPB);

    send_frame(8'h55, 1'b1, 1, 4);
    idle(2 * CPB);
    send_frame(8'h81, 1'b1, 0, 0);
    idle(2 * CPB);
    check("after_enable_drop", rx_data, 8'h81);

    send_frame(8'h99, 1'b1, 2, 2);
    idle(2 * CPB);
    send_frame(8'h7E, 1'b1, 0, 0);
    idle(2 * CPB);
    check("after_reset_frame", rx_data, 8'h7E);

    for (int n = 0; n < 20; n++) begin
      send_frame(8'($urandom), $urandom_range(0, 4) != 0, 0, 0);
      idle($urandom_range(1, 3) * CPB + $urandom_range(0, 7));
    end

    idle(2 * CPB);
    check("pending_pulses", exp_q.size(), 0);
    check("final_rx_data", rx_data, last_good);
    check("final_busy", rx_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
